// File: rtl/sbqm_sensor_frontend.sv
// Sensor front end for the bank-queue manager.
// Cleans up the two active-low door photo-sensors (entry and teller exit)
// and turns them into single-cycle arrival / departure events. Each event
// is gated against the manager's full / empty flags, and each sensor is
// flagged if it stays asserted too long.
//
// Channel FSM (one per sensor):
//   state     | meaning
//   ----------+------------------------------------------------------------
//   ST_IDLE   | debounced sensor released, waiting for the next press
//   ST_ACTIVE | press accepted and event issued; timing how long it is held
//   ST_STUCK  | held for STUCK_CYCLES or longer; fault raised until release
module sbqm_sensor_frontend #(
    parameter int DEB_CYCLES   = 4,
    parameter int STUCK_CYCLES = 1000,
    parameter int CNT_W        = 10
) (
    input  logic CLK,
    input  logic RESET,
    input  logic sensor_start,
    input  logic sensor_end,
    input  logic Full_flag,
    input  logic Empty_flag,
    output logic enter_pulse,
    output logic leave_pulse,
    output logic reject_full,
    output logic reject_empty,
    output logic start_fault,
    output logic end_fault
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_STUCK  = 2'd2
    } ch_state_t;

    localparam logic [7:0]       DEB_LAST   = 8'(DEB_CYCLES - 1);
    localparam logic [7:0]       DCNT_ONE   = 8'd1;
    localparam logic [CNT_W-1:0] STUCK_LAST = CNT_W'(STUCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] STUCK_MAX  = CNT_W'(STUCK_CYCLES);
    localparam logic [CNT_W-1:0] SCNT_ONE   = CNT_W'(1);

    // Channel 0 is the entry sensor, channel 1 the exit sensor.
    logic [1:0] raw;
    logic [1:0] sync_a;
    logic [1:0] sync_b;
    logic [1:0] ev;
    logic [1:0] fault;

    logic       pend_leave;

    assign raw = {sensor_end, sensor_start};

    // Two-flop synchroniser for both raw sensors; idles high like the sensors.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync_a <= 2'b11;
            sync_b <= 2'b11;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_ch
        logic             sync_s;
        logic             deb_r;
        logic             deb_nxt;
        logic [7:0]       dcnt;
        logic             ev_r;
        logic             fault_r;
        logic [CNT_W-1:0] scnt;
        ch_state_t        state;

        assign sync_s   = sync_b[g];
        assign ev[g]    = ev_r;
        assign fault[g] = fault_r;

        // Accepted level for this cycle: flips once the synchronised input has
        // disagreed for DEB_CYCLES consecutive cycles.
        always_comb begin
            deb_nxt = deb_r;
            if ((sync_s != deb_r) && (dcnt == DEB_LAST)) begin
                deb_nxt = sync_s;
            end
        end

        // Debounce counter, accepted level, and registered press event.
        always_ff @(posedge CLK or posedge RESET) begin
            if (RESET) begin
                deb_r <= 1'b1;
                dcnt  <= '0;
                ev_r  <= 1'b0;
            end else begin
                deb_r <= deb_nxt;
                ev_r  <= deb_r & ~deb_nxt;
                if ((sync_s == deb_r) || (dcnt == DEB_LAST)) begin
                    dcnt <= '0;
                end else begin
                    dcnt <= dcnt + DCNT_ONE;
                end
            end
        end

        // Hold-time FSM. It follows the accepted level of the same edge so a
        // release clears the fault together with the debounced rise.
        always_ff @(posedge CLK or posedge RESET) begin
            if (RESET) begin
                state   <= ST_IDLE;
                scnt    <= '0;
                fault_r <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (deb_r && !deb_nxt) begin
                            state <= ST_ACTIVE;
                            scnt  <= '0;
                        end
                    end
                    ST_ACTIVE: begin
                        if (deb_nxt) begin
                            state <= ST_IDLE;
                            scnt  <= '0;
                        end else if (scnt == STUCK_LAST) begin
                            state   <= ST_STUCK;
                            scnt    <= STUCK_MAX;
                            fault_r <= 1'b1;
                        end else begin
                            scnt <= scnt + SCNT_ONE;
                        end
                    end
                    ST_STUCK: begin
                        // Counter stays saturated at STUCK_MAX while stuck.
                        if (deb_nxt) begin
                            state   <= ST_IDLE;
                            scnt    <= '0;
                            fault_r <= 1'b0;
                        end
                    end
                    default: begin
                        state   <= ST_IDLE;
                        scnt    <= '0;
                        fault_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign start_fault = fault[0];
    assign end_fault   = fault[1];

    // Arbitration and gating. Entry wins a tie; the exit is parked for one
    // cycle and gated against the empty flag seen when it is finally issued.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            enter_pulse  <= 1'b0;
            leave_pulse  <= 1'b0;
            reject_full  <= 1'b0;
            reject_empty <= 1'b0;
            pend_leave   <= 1'b0;
        end else begin
            enter_pulse  <= 1'b0;
            leave_pulse  <= 1'b0;
            reject_full  <= 1'b0;
            reject_empty <= 1'b0;
            pend_leave   <= 1'b0;

            if (pend_leave) begin
                leave_pulse  <= ~Empty_flag;
                reject_empty <= Empty_flag;
            end

            if (ev[0]) begin
                enter_pulse <= ~Full_flag;
                reject_full <= Full_flag;
            end

            if (ev[1]) begin
                if (ev[0] || pend_leave) begin
                    pend_leave <= 1'b1;
                end else begin
                    leave_pulse  <= ~Empty_flag;
                    reject_empty <= Empty_flag;
                end
            end
        end
    end

endmodule
